conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
- Parametrised streaming 3x3 "valid" convolution over a raster-scanned single-channel image of IMG_W x IMG_H pixels.
- Two line buffers plus a 3x3 window feed a registered 9-way multiply, an adder tree, and a bias/ReLU/saturate stage.
- Kernel weights and bias are runtime-loadable through a coefficient write port.
- Valid/ready handshakes on input and output; the block sits between the pixel source and the next feature-map stage.

Parameters:
- DATA_W, 16: signed input pixel width.
- COEF_W, 16: signed weight and bias width.
- IMG_W, 28: pixels per row, minimum 3.
- IMG_H, 28: rows per frame, minimum 3.
- OUT_W, 32: signed output width; the result saturates to this width.
- ACC_W, DATA_W+COEF_W+4: internal accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_data  in  DATA_W  signed pixel, raster order, row 0 col 0 first.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  signed convolution result.
- out_last  out  1  marks the final result of the frame.
- relu_en  in  1  clamp negative results to 0; sampled at the output stage.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  0..8 select weight k(r,c) at index 3r+c; 9 selects bias; 10..15 are ignored.
- coef_data  in  COEF_W  signed coefficient value.
- busy  out  1  a frame is in progress or the pipeline is non-empty.
- coef_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (asynchronous, active-high):
  - in_ready=0 while reset is asserted; in_ready=1 the first cycle after release.
  - out_valid=0, out_data=0, out_last=0, busy=0, coef_err=0.
  - Row/column counters=0; all weights and the bias=0; pipeline valid bits cleared.
  - Line buffers are not cleared, because their contents are masked by the counters.
- Input acceptance:
  - A pixel is accepted when in_valid && in_ready.
  - col increments on each accept and wraps at IMG_W-1, which increments row.
  - At row=IMG_H-1, col=IMG_W-1 both counters wrap to 0 and the next frame begins.
- Window:
  - On accept, the pixel shifts into the window and into the line buffers.
  - The accepted pixel is window position (2,2); (0,0) is the pixel two rows up and two columns left.
  - A window is complete when row>=2 && col>=2, counted at the accepted pixel.
  - Incomplete windows generate no output.
  - Each frame yields (IMG_W-2)*(IMG_H-2) results.
- Pipeline, 3 stages:
  - S1: nine signed products DATA_W x COEF_W are registered.
  - S2: the adder tree sum is sign-extended to ACC_W and registered.
  - S3: add the sign-extended bias, apply ReLU if relu_en, saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and register to out_data.
  - Latency: out_valid rises 3 cycles after the accept of a completing pixel, absent stall.
- Backpressure:
  - stall = out_valid && !out_ready.
  - During a stall all stages, counters and the window hold.
  - in_ready = !stall && !reset.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - No result is dropped or duplicated; results are delivered in raster order.
- out_last:
  - Asserted with the result whose completing pixel was row IMG_H-1, col IMG_W-1.
- busy:
  - Set on the first accept of a frame.
  - Cleared the cycle after the out_last result is accepted.
- Coefficient writes:
  - Accepted only when busy=0 and no accept occurs in the same cycle.
  - A write issued while busy, or coincident with the first accept of a frame, is ignored and pulses coef_err.
  - An accepted write takes effect for the next frame.
  - Writes to addr 10..15 are ignored without raising coef_err.
- Reset mid-frame:
  - Partial frame is discarded; coefficients are cleared.
  - The next accepted pixel is treated as row 0, col 0.

Decomposition:
- Shared package conv_pkg:
  - Default widths DATA_W/COEF_W/OUT_W.
  - Constants K_TAPS=9, BIAS_ADDR=4'd9.
  - A saturate function taking ACC_W to OUT_W.
- Sub-module conv3x3_window:
  - Contains the two IMG_W-deep line buffers, the 3x3 shift window, and the row/col counters with the window-complete flag.
  - Has a hold (stall) input; outputs the 9 taps and a last flag.
- The top level holds the MAC tree, the output stage, the handshake logic and the coefficient registers.

Test Plan:
- Identity kernel (k(1,1)=1, rest 0, bias 0) with IMG_W=5, IMG_H=4 and pixels 0..19 in raster order -> outputs 6,7,8,11,12,13, out_last on 13, first out_valid 3 cycles after pixel 12 is accepted.
- All weights 1, bias -9000, relu_en=1, constant image 1000 -> every output 0; with bias -9001 -> every output 0 (clamped); with relu_en=0 and bias -9001 -> every output -1.
- OUT_W=16, all weights 32767, all pixels 32767 -> every output 32767; pixels -32768 -> every output -32768.
- out_ready=0 for 5 cycles after the 2nd result with in_valid held high -> in_ready=0 throughout, out_data stable, full sequence intact and in order.
- coef_we to addr 4 while busy=1 -> coef_err pulses for 1 cycle, current-frame outputs unchanged; the same write after busy falls -> the next frame uses the new weight.
- reset pulsed after 7 pixels of a 5x4 frame, then coefficients reloaded and a full frame sent -> all outputs 0 immediately after the reset edge, then exactly 6 correct results from the new frame.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared widths, coefficient map constants and saturation helper
//            for the streaming 3x3 convolution.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int COEF_W_DEF = 16;
    localparam int OUT_W_DEF  = 32;

    localparam int         K_TAPS    = 9;
    localparam logic [3:0] BIAS_ADDR = 4'd9;

    // Working width of the saturation helper; must exceed ACC_W + 1.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] val,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] w_hi;
        logic signed [SAT_W-1:0] w_lo;
        w_hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        w_lo = -w_hi - 64'sd1;
        if (val > w_hi) begin
            return w_hi;
        end
        if (val < w_lo) begin
            return w_lo;
        end
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_window.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_window
// Brief    : Two line buffers, 3x3 shift window and raster counters; flags
//            windows that lie fully inside the image.
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_window
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_hold,
    input  logic                     i_accept,
    input  logic signed [DATA_W-1:0] i_pix,
    output logic signed [DATA_W-1:0] o_taps [K_TAPS],
    output logic                     o_win_valid,
    output logic                     o_win_last,
    output logic                     o_at_end
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_MAX = c_ROW_W'(IMG_H - 1);

    logic [c_COL_W-1:0]       r_col;
    logic [c_ROW_W-1:0]       r_row;
    logic                     r_vld;
    logic                     r_last;
    logic signed [DATA_W-1:0] r_lb0 [IMG_W];
    logic signed [DATA_W-1:0] r_lb1 [IMG_W];
    logic signed [DATA_W-1:0] r_win [K_TAPS];

    logic w_shift;
    logic w_col_end;
    logic w_row_end;
    logic w_complete;

    assign w_shift    = i_accept && !i_hold;
    assign w_col_end  = (r_col == c_COL_MAX);
    assign w_row_end  = (r_row == c_ROW_MAX);
    assign w_complete = (r_row >= c_ROW_W'(2)) && (r_col >= c_COL_W'(2));
    assign o_at_end   = w_col_end && w_row_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else if (!i_hold) begin
            r_vld  <= w_shift && w_complete;
            r_last <= w_shift && w_col_end && w_row_end;
            if (w_shift) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + c_ROW_W'(1);
                end else begin
                    r_col <= r_col + c_COL_W'(1);
                end
            end
        end
    end

    // Stale line-buffer data is never used: the counters mask incomplete windows.
    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_lb0[r_col] <= i_pix;
            r_lb1[r_col] <= r_lb0[r_col];
            for (int r = 0; r < 3; r++) begin
                r_win[3*r]   <= r_win[3*r+1];
                r_win[3*r+1] <= r_win[3*r+2];
            end
            r_win[2] <= r_lb1[r_col];
            r_win[5] <= r_lb0[r_col];
            r_win[8] <= i_pix;
        end
    end

    assign o_taps      = r_win;
    assign o_win_valid = r_vld;
    assign o_win_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream
// Brief    : Streaming 3x3 valid convolution with loadable weights/bias,
//            ReLU and output saturation, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ACC_W  = DATA_W + COEF_W + 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    input  logic                     relu_en,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     busy,
    output logic                     coef_err
);

    localparam int c_PROD_W = DATA_W + COEF_W;

    logic w_stall;
    logic w_accept;
    logic w_coef_hit;
    logic w_coef_reject;
    logic w_win_valid;
    logic w_win_last;
    logic w_at_end;

    logic signed [DATA_W-1:0]   w_taps [K_TAPS];
    logic signed [c_PROD_W-1:0] w_prod [K_TAPS];
    logic signed [ACC_W-1:0]    w_tree;
    logic signed [SAT_W-1:0]    w_biased;
    logic signed [SAT_W-1:0]    w_relu;
    logic signed [SAT_W-1:0]    w_sat;
    logic                       w_unused_sat_hi;

    logic                       r_frame_open;
    logic signed [COEF_W-1:0]   r_coef [K_TAPS];
    logic signed [COEF_W-1:0]   r_bias;
    logic                       r_coef_err;
    logic signed [c_PROD_W-1:0] r_prod [K_TAPS];
    logic                       r_s1_vld;
    logic                       r_s1_last;
    logic signed [ACC_W-1:0]    r_sum;
    logic                       r_s2_vld;
    logic                       r_s2_last;
    logic                       r_out_valid;
    logic                       r_out_last;
    logic signed [OUT_W-1:0]    r_out_data;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall && !reset;
    assign w_accept = in_valid && in_ready;
    assign busy     = r_frame_open || w_win_valid || r_s1_vld || r_s2_vld || r_out_valid;

    conv3x3_window #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .i_hold      (w_stall),
        .i_accept    (w_accept),
        .i_pix       (in_data),
        .o_taps      (w_taps),
        .o_win_valid (w_win_valid),
        .o_win_last  (w_win_last),
        .o_at_end    (w_at_end)
    );

    // A write arriving with the first pixel of a frame is rejected like one mid-frame.
    assign w_coef_hit    = coef_we && (coef_addr <= BIAS_ADDR);
    assign w_coef_reject = w_coef_hit && (busy || w_accept);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < K_TAPS; k++) begin
                r_coef[k] <= '0;
            end
            r_bias       <= '0;
            r_coef_err   <= 1'b0;
            r_frame_open <= 1'b0;
        end else begin
            r_coef_err <= w_coef_reject;
            if (w_accept) begin
                r_frame_open <= !w_at_end;
            end
            if (w_coef_hit && !w_coef_reject) begin
                if (coef_addr == BIAS_ADDR) begin
                    r_bias <= coef_data;
                end else begin
                    r_coef[coef_addr] <= coef_data;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < K_TAPS; k++) begin
            w_prod[k] = $signed({{COEF_W{w_taps[k][DATA_W-1]}}, w_taps[k]})
                      * $signed({{DATA_W{r_coef[k][COEF_W-1]}}, r_coef[k]});
        end
    end

    always_comb begin
        w_tree = '0;
        for (int k = 0; k < K_TAPS; k++) begin
            w_tree = w_tree + {{(ACC_W-c_PROD_W){r_prod[k][c_PROD_W-1]}}, r_prod[k]};
        end
    end

    always_comb begin
        w_biased = {{(SAT_W-ACC_W){r_sum[ACC_W-1]}}, r_sum}
                 + {{(SAT_W-COEF_W){r_bias[COEF_W-1]}}, r_bias};
        w_relu   = (relu_en && w_biased[SAT_W-1]) ? '0 : w_biased;
        w_sat    = saturate(w_relu, OUT_W);
    end

    assign w_unused_sat_hi = ^w_sat[SAT_W-1:OUT_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < K_TAPS; k++) begin
                r_prod[k] <= '0;
            end
            r_s1_vld    <= 1'b0;
            r_s1_last   <= 1'b0;
            r_sum       <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (!w_stall) begin
            for (int k = 0; k < K_TAPS; k++) begin
                r_prod[k] <= w_prod[k];
            end
            r_s1_vld    <= w_win_valid;
            r_s1_last   <= w_win_last;
            r_sum       <= w_tree;
            r_s2_vld    <= r_s1_vld;
            r_s2_last   <= r_s1_last;
            r_out_valid <= r_s2_vld;
            r_out_last  <= r_s2_last;
            if (r_s2_vld) begin
                r_out_data <= w_sat[OUT_W-1:0];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign coef_err  = r_coef_err;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_stream
// Brief    : Scoreboard bench for conv3x3_stream on a 5x4 image, 16-bit output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;
    localparam int OUT_W  = 16;
    localparam int NPIX   = IMG_W * IMG_H;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_last;
    logic                     relu_en;
    logic                     coef_we;
    logic [3:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     busy;
    logic                     coef_err;

    conv3x3_stream #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .relu_en   (relu_en),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .coef_err  (coef_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        logic   last;
    } exp_t;

    int     n_checks  = 0;
    int     n_fail    = 0;
    int     cyc       = 0;
    int     first_vld = -1;
    int     acc12     = 0;
    longint m_k [9];
    longint m_bias;
    longint img [NPIX];
    exp_t   sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Direct-form reference: every window recomputed from the whole image.
    function automatic void push_expected();
        longint hi;
        longint lo;
        exp_t   e;
        hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        for (int r = 2; r < IMG_H; r++) begin
            for (int c = 2; c < IMG_W; c++) begin
                longint acc;
                acc = m_bias;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += m_k[3*i+j] * img[(r-2+i)*IMG_W + (c-2+j)];
                if (relu_en && acc < 0) acc = 0;
                if (acc > hi) acc = hi;
                if (acc < lo) acc = lo;
                e.data = acc;
                e.last = (r == IMG_H-1) && (c == IMG_W-1);
                sb.push_back(e);
            end
        end
    endfunction

    // Output monitor: scoreboard pop plus hold-stability during stalls.
    logic                    prev_stall = 1'b0;
    logic signed [OUT_W-1:0] prev_data  = '0;
    logic                    prev_last  = 1'b0;
    exp_t                    mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", out_data, mon_e.data);
                    check("out_last", out_last, mon_e.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic write_coef(input logic [3:0] a, input longint d, input bit exp_err);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d[COEF_W-1:0];
        @(posedge clk); #1;
        coef_we = 1'b0;
        @(negedge clk);
        check("coef_err", coef_err, exp_err);
        if (!exp_err && a <= 4'd9) begin
            if (a == 4'd9) m_bias = d;
            else m_k[a] = d;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_pixel(input longint v, output int acc_cyc);
        bit ok     = 1'b0;
        int waited = 0;
        in_valid = 1'b1;
        in_data  = v[DATA_W-1:0];
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (!ok) begin
                waited++;
                if (waited > 100) begin
                    check("in_ready_timeout", 0, 1);
                    ok = 1'b1;
                end
            end
        end
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_frame();
        int c;
        push_expected();
        for (int i = 0; i < NPIX; i++) begin
            send_pixel(img[i], c);
            if (i == 0) check("busy_set", busy, 1);
            if (i == 12) acc12 = c;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_queue", sb.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    task automatic set_kernel(input longint w, input longint centre);
        for (int k = 0; k < 9; k++) write_coef(4'(k), (k == 4) ? centre : w, 1'b0);
    endtask

    task automatic stall_ctrl();
        int seen = 0;
        int t    = 0;
        while (seen < 2 && t < 200) begin
            @(negedge clk);
            if (out_valid && out_ready) seen++;
            t++;
        end
        check("bp_reach_second", seen, 2);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        relu_en = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        for (int k = 0; k < 9; k++) m_k[k] = 0;
        m_bias = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_coef_err", coef_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Identity kernel, ramp image, latency of the first result
        write_coef(4'd12, 77, 1'b0);
        write_coef(4'd4, 1, 1'b0);
        for (int i = 0; i < NPIX; i++) img[i] = i;
        first_vld = -1;
        send_frame();
        wait_drain();
        check("latency", first_vld - acc12, 3);

        // Bias and ReLU
        set_kernel(1, 1);
        write_coef(4'd9, -9000, 1'b0);
        relu_en = 1'b1;
        for (int i = 0; i < NPIX; i++) img[i] = 1000;
        send_frame(); wait_drain();
        write_coef(4'd9, -9001, 1'b0);
        send_frame(); wait_drain();
        relu_en = 1'b0;
        send_frame(); wait_drain();

        // Saturation at both rails
        set_kernel(32767, 32767);
        write_coef(4'd9, 0, 1'b0);
        for (int i = 0; i < NPIX; i++) img[i] = 32767;
        send_frame(); wait_drain();
        for (int i = 0; i < NPIX; i++) img[i] = -32768;
        send_frame(); wait_drain();

        // Backpressure after the second result
        set_kernel(0, 1);
        for (int i = 0; i < NPIX; i++) img[i] = i;
        fork
            send_frame();
            stall_ctrl();
        join
        wait_drain();

        // Rejected write while busy, then accepted write for the next frame
        for (int i = 0; i < NPIX; i++) img[i] = i + 100;
        fork
            send_frame();
            begin
                repeat (4) @(posedge clk);
                #1;
                write_coef(4'd4, 2, 1'b1);
                @(negedge clk);
                check("coef_err_one_cycle", coef_err, 0);
                write_coef(4'd12, 3, 1'b0);
            end
        join
        wait_drain();
        write_coef(4'd4, 2, 1'b0);
        for (int i = 0; i < NPIX; i++) img[i] = i;
        send_frame(); wait_drain();

        // Reset in the middle of a frame
        for (int i = 0; i < 7; i++) send_pixel(img[i], c);
        check("pre_reset_data", out_data, 26);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        for (int k = 0; k < 9; k++) m_k[k] = 0;
        m_bias = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        write_coef(4'd0, 1, 1'b0);
        send_frame(); wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
